freq_div_ctrl: RTL and testbench

Sequencer and arbiter that shares one frequency divider's divisor among NUM_REQ requesters. Each divisor change is applied glitch-free in a fixed order: gate the divided clock, pulse the divider reset while loading the new divisor, wait for it to settle, re-enable the clock, then acknowledge the winning requester. The block sits between software/power-management requesters and the divider instance plus its downstream clock gate.

---
 rtl/freq_div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_freq_div_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// Glitch-free divisor sequencer: round-robin arbitration among requesters, then
// gate -> divider reset with new divisor -> settle -> re-enable -> acknowledge.
module freq_div_ctrl #(
    parameter int NUM_REQ       = 4,
    parameter int DIVISOR_SIZE  = 9,
    parameter int GATE_CYC      = 4,
    parameter int SETTLE_CYC    = 2,
    parameter int RESET_DIVISOR = 1
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ*DIVISOR_SIZE-1:0]   divisor_i,
    output logic [NUM_REQ-1:0]                ack_o,
    output logic [DIVISOR_SIZE-1:0]           divisor_o,
    output logic                              div_arst_no,
    output logic                              clk_en_o,
    output logic                              busy_o,
    output logic [$clog2(NUM_REQ)-1:0]        grant_idx_o
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int MAXC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_GATE, S_RST, S_SETTLE, S_ACK
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    no_ack_q, no_ack_d;
    logic [IW-1:0]           rr_q, rr_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic [DIVISOR_SIZE-1:0] div_lat_q, div_lat_d;
    logic [DIVISOR_SIZE-1:0] divisor_q, divisor_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    div_rst_n_q, div_rst_n_d;
    logic                    clk_en_q, clk_en_d;
    logic                    busy_q, busy_d;

    logic                    found;
    logic [IW-1:0]           win;
    logic [DIVISOR_SIZE-1:0] win_div;
    int                      k;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_div = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_q) + i) % NUM_REQ;
            if (!found && req_i[k]) begin
                found   = 1'b1;
                win     = IW'(k);
                win_div = divisor_i[k*DIVISOR_SIZE +: DIVISOR_SIZE];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        no_ack_d    = no_ack_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        div_lat_d   = div_lat_q;
        divisor_d   = divisor_q;
        ack_d       = '0;
        div_rst_n_d = div_rst_n_q;
        clk_en_d    = clk_en_q;
        case (state_q)
            S_INIT: begin
                state_d     = S_SETTLE;
                cnt_d       = '0;
                no_ack_d    = 1'b1;
                div_rst_n_d = 1'b1;
            end
            S_IDLE: begin
                if (found) begin
                    grant_d   = win;
                    div_lat_d = win_div;
                    rr_d      = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
                    // Same divisor already applied: acknowledge without touching the divider.
                    if (win_div == divisor_q) begin
                        state_d    = S_ACK;
                        ack_d[win] = 1'b1;
                        clk_en_d   = 1'b1;
                    end else begin
                        state_d  = S_GATE;
                        cnt_d    = '0;
                        clk_en_d = 1'b0;
                    end
                end
            end
            S_GATE: begin
                if (cnt_q == CW'(GATE_CYC - 1)) begin
                    state_d     = S_RST;
                    div_rst_n_d = 1'b0;
                    divisor_d   = div_lat_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RST: begin
                state_d     = S_SETTLE;
                cnt_d       = '0;
                div_rst_n_d = 1'b1;
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                    clk_en_d = 1'b1;
                    // Power-up settle returns to IDLE silently; nobody asked for it.
                    if (no_ack_q) begin
                        state_d  = S_IDLE;
                        no_ack_d = 1'b0;
                    end else begin
                        state_d        = S_ACK;
                        ack_d[grant_q] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            no_ack_q    <= 1'b0;
            rr_q        <= '0;
            grant_q     <= '0;
            div_lat_q   <= DIVISOR_SIZE'(RESET_DIVISOR);
            divisor_q   <= DIVISOR_SIZE'(RESET_DIVISOR);
            ack_q       <= '0;
            div_rst_n_q <= 1'b0;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            no_ack_q    <= no_ack_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            div_lat_q   <= div_lat_d;
            divisor_q   <= divisor_d;
            ack_q       <= ack_d;
            div_rst_n_q <= div_rst_n_d;
            clk_en_q    <= clk_en_d;
            busy_q      <= busy_d;
        end
    end

    assign ack_o       = ack_q;
    assign divisor_o   = divisor_q;
    assign div_arst_no = div_rst_n_q;
    assign clk_en_o    = clk_en_q;
    assign busy_o      = busy_q;
    assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: cycle-accurate sequence checks plus an ack scoreboard
// holding {grant index, divisor} for every request issued.
module tb_freq_div_ctrl;
  localparam int NR = 4;
  localparam int DS = 9;
  localparam int GC = 4;
  localparam int SC = 2;
  localparam int W  = 2 + DS;

  logic            clk_i = 1'b0;
  logic            arst_ni = 1'b0;
  logic [NR-1:0]   req_i = '0;
  logic [NR*DS-1:0] divisor_i = '0;
  logic [NR-1:0]   ack_o;
  logic [DS-1:0]   divisor_o;
  logic            div_arst_no;
  logic            clk_en_o;
  logic            busy_o;
  logic [1:0]      grant_idx_o;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_acks = 0;
  int exp_acks = 0;

  freq_div_ctrl #(
    .NUM_REQ(NR), .DIVISOR_SIZE(DS), .GATE_CYC(GC), .SETTLE_CYC(SC), .RESET_DIVISOR(1)
  ) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .req_i(req_i), .divisor_i(divisor_i),
    .ack_o(ack_o), .divisor_o(divisor_o), .div_arst_no(div_arst_no),
    .clk_en_o(clk_en_o), .busy_o(busy_o), .grant_idx_o(grant_idx_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every ack pulse must match the oldest outstanding request
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (arst_ni && ack_o != '0) begin
      n_acks++;
      check_eq("ack_onehot", $countones(ack_o), 1);
      if (exp_q.size() == 0) begin
        check_eq("ack_unexpected", ack_o, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_ack", ack_o, 32'(4'b0001 << e[W-1:DS]));
        check_eq("sb_div", divisor_o, e[DS-1:0]);
        check_eq("sb_grant", grant_idx_o, e[W-1:DS]);
      end
    end
  end

  // driver tasks
  task automatic reset_and_init();
    arst_ni = 1'b0;
    req_i   = '0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_div_rst_n", div_arst_no, 0);
    check_eq("rst_clk_en", clk_en_o, 0);
    check_eq("rst_busy", busy_o, 1);
    check_eq("rst_divisor", divisor_o, 1);
    check_eq("rst_ack", ack_o, 0);
    check_eq("rst_grant", grant_idx_o, 0);
    arst_ni = 1'b1;
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clk_i);
      check_eq("init_div_rst_n", div_arst_no, 1);
      check_eq("init_clk_en", clk_en_o, (k == SC + 1) ? 1 : 0);
      check_eq("init_busy", busy_o, (k == SC + 1) ? 0 : 1);
      check_eq("init_divisor", divisor_o, 1);
      check_eq("init_ack", ack_o, 0);
    end
  endtask

  // Called at a negedge with the DUT idle; the next posedge is the grant edge E0.
  task automatic do_grant(input logic [NR-1:0] req, input int idx, input logic [DS-1:0] dv,
                          input bit shortcut);
    int ack_k;
    int last;
    req_i = req;
    exp_q.push_back({2'(idx), dv});
    exp_acks++;
    ack_k = shortcut ? 0 : GC + SC + 1;
    last  = ack_k + 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        check_eq("grant_idx", grant_idx_o, idx);
        divisor_i[idx*DS +: DS] = DS'($urandom_range(0, (1 << DS) - 1));
      end
      check_eq("seq_ack", ack_o, (k == ack_k) ? 32'(4'b0001 << idx) : 0);
      check_eq("seq_clk_en", clk_en_o, (k >= ack_k) ? 1 : 0);
      check_eq("seq_div_rst_n", div_arst_no, (!shortcut && k == GC) ? 0 : 1);
      check_eq("seq_busy", busy_o, (k == last) ? 0 : 1);
      if (shortcut || k >= GC) check_eq("seq_divisor", divisor_o, dv);
      if (k == ack_k) req_i[idx] = 1'b0;
    end
  endtask

  initial begin
    // 1: reset release with no requests
    reset_and_init();

    // 2: normal path, requester 0 to divisor 6
    divisor_i[0*DS +: DS] = 9'd6;
    do_grant(4'b0001, 0, 9'd6, 1'b0);

    // 3: same divisor again takes the shortcut
    divisor_i[0*DS +: DS] = 9'd6;
    do_grant(4'b0001, 0, 9'd6, 1'b1);

    // shortcut on requester 3 moves the round-robin pointer back to 0
    divisor_i[3*DS +: DS] = 9'd6;
    do_grant(4'b1000, 3, 9'd6, 1'b1);

    // 4: all four request together; each drops on its ack
    divisor_i = {9'd9, 9'd7, 9'd5, 9'd3};
    do_grant(4'b1111, 0, 9'd3, 1'b0);
    do_grant(4'b1110, 1, 9'd5, 1'b0);
    do_grant(4'b1100, 2, 9'd7, 1'b0);
    do_grant(4'b1000, 3, 9'd9, 1'b0);

    // 5: after a grant to 2, 0101 wraps around to 0
    divisor_i[2*DS +: DS] = 9'd100;
    do_grant(4'b0100, 2, 9'd100, 1'b0);
    divisor_i[0*DS +: DS] = 9'd17;
    divisor_i[2*DS +: DS] = 9'd18;
    do_grant(4'b0101, 0, 9'd17, 1'b0);
    do_grant(4'b0100, 2, 9'd18, 1'b0);

    // 6: reset during GATE
    divisor_i[1*DS +: DS] = 9'd12;
    req_i = 4'b0010;
    repeat (3) @(negedge clk_i);
    check_eq("gate_clk_en", clk_en_o, 0);
    arst_ni = 1'b0;
    req_i   = '0;
    #1;
    check_eq("midrst_clk_en", clk_en_o, 0);
    check_eq("midrst_div_rst_n", div_arst_no, 0);
    check_eq("midrst_divisor", divisor_o, 1);
    check_eq("midrst_ack", ack_o, 0);
    check_eq("midrst_grant", grant_idx_o, 0);
    reset_and_init();
    divisor_i[1*DS +: DS] = 9'd12;
    do_grant(4'b0010, 1, 9'd12, 1'b0);

    // divisor 0 and 1 pass through unchanged
    divisor_i[2*DS +: DS] = 9'd0;
    do_grant(4'b0100, 2, 9'd0, 1'b0);
    divisor_i[3*DS +: DS] = 9'd1;
    do_grant(4'b1000, 3, 9'd1, 1'b0);

    repeat (4) @(negedge clk_i);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("ack_count", n_acks, exp_acks);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
